// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } dmem_state_e;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 4;

    function automatic bit latency_ok(input int lat);
        return (lat >= READ_LATENCY_MIN) && (lat <= READ_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/byte_we_ram.sv
// rtl/byte_we_ram.sv - word array with per-byte write enables and a registered read port
module byte_we_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Storage is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - dmem request responder: range check, read-latency FSM, handshake
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_dmem_addr,
    input  logic        i_dmem_ren,
    input  logic        i_dmem_wen,
    input  logic [31:0] i_dmem_wdata,
    input  logic [3:0]  i_dmem_mask,
    output logic [31:0] o_dmem_rdata,
    output logic        o_dmem_rvalid,
    output logic        o_dmem_busy,
    output logic        o_dmem_fault
);

    localparam int         ADDR_W   = $clog2(DEPTH_WORDS);
    localparam logic [2:0] CNT_LOAD = 3'(READ_LATENCY - 1);

    if (!latency_ok(READ_LATENCY) || DEPTH_WORDS < 4 ||
        (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_param_check
        $error("dmem_responder: illegal DEPTH_WORDS or READ_LATENCY");
    end

    dmem_state_e       state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] req_idx, rd_idx_q, rd_idx;
    logic              req_oor, rd_oor_q, rd_oor;
    logic              idle, acc_wr, acc_rd, acc_both, read_fire;
    logic              zero_q, rvalid_q, fault_q;
    logic [3:0]        ram_we;
    logic [31:0]       ram_rdata;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^i_dmem_addr[1:0];
    assign req_idx  = i_dmem_addr[ADDR_W+1:2];
    assign req_oor  = |i_dmem_addr[31:ADDR_W+2];

    assign idle     = (state_q == ST_IDLE);
    assign acc_wr   = idle & i_dmem_wen & ~i_dmem_ren;
    assign acc_rd   = idle & i_dmem_ren & ~i_dmem_wen;
    assign acc_both = idle & i_dmem_ren & i_dmem_wen;

    // A conflicting ren+wen still commits the write; only the read is dropped.
    assign ram_we = ((acc_wr | acc_both) & ~req_oor) ? i_dmem_mask : 4'b0000;

    // Single-cycle reads use the live request; longer ones use the captured index.
    assign read_fire = (READ_LATENCY == 1) ? acc_rd
                                           : ((state_q == ST_WAIT) && (cnt_q == 3'd1));
    assign rd_idx    = (READ_LATENCY == 1) ? req_idx : rd_idx_q;
    assign rd_oor    = (READ_LATENCY == 1) ? req_oor : rd_oor_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (acc_rd && READ_LATENCY > 1) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_idx_q <= '0;
            rd_oor_q <= 1'b0;
            zero_q   <= 1'b0;
            rvalid_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            if (acc_rd) begin
                rd_idx_q <= req_idx;
                rd_oor_q <= req_oor;
            end
            if (read_fire) begin
                zero_q <= rd_oor;
            end
            rvalid_q <= read_fire;
            fault_q  <= (acc_wr & req_oor) | acc_both | (read_fire & rd_oor);
        end
    end

    byte_we_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk  (i_clk),
        .rst_n(i_rst_n),
        .we   (ram_we),
        .waddr(req_idx),
        .wdata(i_dmem_wdata),
        .re   (read_fire & ~rd_oor),
        .raddr(rd_idx),
        .rdata(ram_rdata)
    );

    assign o_dmem_rdata  = zero_q ? 32'h0 : ram_rdata;
    assign o_dmem_rvalid = rvalid_q;
    assign o_dmem_busy   = (state_q != ST_IDLE);
    assign o_dmem_fault  = fault_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized bench for dmem_responder at latencies 1, 3 and 4
module tb_dmem_responder;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] addr [3];
    logic [31:0] wdata[3];
    logic        ren  [3];
    logic        wen  [3];
    logic [3:0]  mask [3];
    logic [31:0] rdata [3];
    logic        rvalid[3];
    logic        busy  [3];
    logic        fault [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS (1024),
            .READ_LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 4))
        ) u_dut (
            .i_clk        (clk),
            .i_rst_n      (rst_n),
            .i_dmem_addr  (addr[g]),
            .i_dmem_ren   (ren[g]),
            .i_dmem_wen   (wen[g]),
            .i_dmem_wdata (wdata[g]),
            .i_dmem_mask  (mask[g]),
            .o_dmem_rdata (rdata[g]),
            .o_dmem_rvalid(rvalid[g]),
            .o_dmem_busy  (busy[g]),
            .o_dmem_fault (fault[g])
        );
    end

    int lat[3] = '{1, 3, 4};

    // Reference model: memory image plus "which edge answers, which edges are blocked".
    logic [31:0] mmem [3][1024];
    int          edge_n = 0;
    int          block_until[3] = '{-1, -1, -1};
    int          resp_edge  [3] = '{-1, -1, -1};
    bit          resp_oor   [3];
    int          resp_idx   [3];
    bit          e_rvalid[3], e_fault[3], e_busy[3];
    logic [31:0] e_rdata [3] = '{32'h0, 32'h0, 32'h0};
    bit          m_oor;
    int          m_idx;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    always @(posedge clk) begin
        edge_n++;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                block_until[k] = -1;
                resp_edge[k]   = -1;
                e_rvalid[k]    = 1'b0;
                e_fault[k]     = 1'b0;
                e_busy[k]      = 1'b0;
                e_rdata[k]     = 32'h0;
            end else begin
                e_rvalid[k] = 1'b0;
                e_fault[k]  = 1'b0;
                m_oor = (addr[k][31:12] != 20'h0);
                m_idx = int'(addr[k][11:2]);
                if (edge_n > block_until[k] && (ren[k] || wen[k])) begin
                    if (wen[k]) begin
                        if (!m_oor)
                            for (int b = 0; b < 4; b++)
                                if (mask[k][b]) mmem[k][m_idx][8*b +: 8] = wdata[k][8*b +: 8];
                        e_fault[k] = m_oor || ren[k];
                    end else begin
                        resp_edge[k] = edge_n + lat[k] - 1;
                        resp_oor[k]  = m_oor;
                        resp_idx[k]  = m_idx;
                        if (lat[k] > 1) block_until[k] = edge_n + lat[k];
                    end
                end
                if (resp_edge[k] == edge_n) begin
                    e_rvalid[k]  = 1'b1;
                    e_fault[k]   = resp_oor[k];
                    e_rdata[k]   = resp_oor[k] ? 32'h0 : mmem[k][resp_idx[k]];
                    resp_edge[k] = -1;
                end
                e_busy[k] = (edge_n < block_until[k]);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("rvalid[%0d]", k), 32'(rvalid[k]), 32'(e_rvalid[k]));
                chk($sformatf("fault[%0d]", k),  32'(fault[k]),  32'(e_fault[k]));
                chk($sformatf("busy[%0d]", k),   32'(busy[k]),   32'(e_busy[k]));
                chk($sformatf("rdata[%0d]", k),  rdata[k],       e_rdata[k]);
            end
        end
    end

    task automatic clr(input int k);
        ren[k]   = 1'b0;
        wen[k]   = 1'b0;
        addr[k]  = 32'h0;
        wdata[k] = 32'h0;
        mask[k]  = 4'h0;
    endtask

    // Present one request for a cycle; returns at the negedge after the edge that sampled it.
    task automatic req(input int k, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
        ren[k] = r; wen[k] = w; addr[k] = a; wdata[k] = d; mask[k] = m;
        @(negedge clk);
        clr(k);
    endtask

    initial begin
        int sel;
        logic [31:0] a;
        for (int k = 0; k < 3; k++) clr(k);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_rdata",  rdata[k],        32'h0);
            chk("reset_rvalid", 32'(rvalid[k]), 32'h0);
            chk("reset_busy",   32'(busy[k]),   32'h0);
            chk("reset_fault",  32'(fault[k]),  32'h0);
        end
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        for (int w = 0; w < 16; w++) begin
            for (int k = 0; k < 3; k++) begin
                wen[k] = 1'b1; addr[k] = 32'(w * 4); wdata[k] = $urandom; mask[k] = MASK_WORD;
            end
            @(negedge clk);
            for (int k = 0; k < 3; k++) clr(k);
        end

        // Latency 1: full, byte and upper-half writes with immediate readback.
        req(0, 0, 1, 32'h10, 32'hDEADBEEF, MASK_WORD);
        req(0, 1, 0, 32'h10, 32'h0, 4'h0);
        chk("l1_rvalid", 32'(rvalid[0]), 32'h1);
        chk("l1_word",   rdata[0],       32'hDEADBEEF);
        chk("l1_busy",   32'(busy[0]),   32'h0);
        req(0, 0, 1, 32'h10, 32'h00AA0000, 4'b0100);
        req(0, 1, 0, 32'h10, 32'h0, 4'h0);
        chk("l1_byte", rdata[0], 32'hDEAABEEF);
        req(0, 0, 1, 32'h12, 32'h12340000, 4'b1100);
        req(0, 1, 0, 32'h10, 32'h0, 4'h0);
        chk("l1_half", rdata[0], 32'h1234BEEF);

        // Latency 3: write presented while busy must be dropped.
        req(1, 0, 1, 32'h20, 32'h0000CAFE, MASK_WORD);
        req(1, 1, 0, 32'h20, 32'h0, MASK_BYTE);
        chk("l3_busy_c1",   32'(busy[1]),   32'h1);
        chk("l3_rvalid_c1", 32'(rvalid[1]), 32'h0);
        req(1, 0, 1, 32'h20, 32'hFFFFFFFF, MASK_WORD);
        chk("l3_busy_c2",   32'(busy[1]),   32'h1);
        @(negedge clk);
        chk("l3_busy_c3",   32'(busy[1]),   32'h1);
        chk("l3_rvalid_c3", 32'(rvalid[1]), 32'h1);
        chk("l3_data",      rdata[1],       32'h0000CAFE);
        @(negedge clk);
        chk("l3_busy_done", 32'(busy[1]),   32'h0);
        req(1, 1, 0, 32'h20, 32'h0, 4'h0);
        repeat (2) @(negedge clk);
        chk("l3_dropped_wr", rdata[1], 32'h0000CAFE);

        // Out-of-range write and read.
        req(0, 0, 1, 32'h0, 32'h55AA55AA, MASK_WORD);
        req(0, 0, 1, 32'h1000, 32'hFFFFFFFF, MASK_WORD);
        chk("oor_wr_fault",  32'(fault[0]),  32'h1);
        chk("oor_wr_rvalid", 32'(rvalid[0]), 32'h0);
        req(0, 1, 0, 32'h1000, 32'h0, 4'h0);
        chk("oor_rd_rvalid", 32'(rvalid[0]), 32'h1);
        chk("oor_rd_fault",  32'(fault[0]),  32'h1);
        chk("oor_rd_data",   rdata[0],       32'h0);
        req(0, 1, 0, 32'h0, 32'h0, 4'h0);
        chk("oor_no_alias", rdata[0], 32'h55AA55AA);

        // Simultaneous read and write.
        req(0, 1, 1, 32'h30, 32'h11223344, MASK_WORD);
        chk("both_fault",  32'(fault[0]),  32'h1);
        chk("both_rvalid", 32'(rvalid[0]), 32'h0);
        req(0, 1, 0, 32'h30, 32'h0, 4'h0);
        chk("both_wr_kept", rdata[0], 32'h11223344);

        // Latency 4: reset in the middle of the wait.
        req(2, 1, 0, 32'h4, 32'h0, 4'h0);
        @(negedge clk);
        chk("l4_busy_wait", 32'(busy[2]), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy_drop", 32'(busy[2]), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("rst_no_rvalid", 32'(rvalid[2]), 32'h0);
        end
        req(2, 1, 0, 32'h4, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        chk("l4_after_rst_rvalid", 32'(rvalid[2]), 32'h1);
        chk("l4_after_rst_data",   rdata[2],       mmem[2][1]);

        // Random traffic, checked every cycle by the compare process.
        repeat (3000) begin
            for (int k = 0; k < 3; k++) begin
                sel = $urandom_range(0, 99);
                a = {22'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
                if ($urandom_range(0, 9) == 0) a[31:12] = 20'($urandom_range(1, 20'hFFFFF));
                addr[k]  = a;
                wdata[k] = $urandom;
                mask[k]  = 4'($urandom_range(0, 15));
                ren[k]   = (sel >= 40 && sel < 70) || sel >= 95;
                wen[k]   = sel >= 70;
            end
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) clr(k);
        repeat (8) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
